// File: rtl/pc_unit.sv
// Program counter with run/pause/halt sequencing, ROM wrap, misaligned-target
// trap, self-loop halt detection and a saturating retired-instruction counter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// PAUSED | idle after reset/clr; waits for step_en to start running
// RUN    | each tick (with step_en high) advances the PC to npc
// HALTED | stopped on trap or self-loop; only clr or rstn leaves it
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              tick,
    input  logic              step_en,
    input  logic              clr,
    input  logic [2:0]        npc_op,
    input  logic [31:0]       immout,
    input  logic [31:0]       rs1_data,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc_plus4_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              retire_o,
    output logic              halted_o,
    output logic              trap_o,
    output logic [15:0]       inst_cnt_o
);

    typedef enum logic [1:0] {PAUSED, RUN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        retire_q, retire_d;
    logic        trap_q, trap_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] pc_inc;
    logic [31:0] npc;

    assign pc_inc     = pc_q + 32'd4;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_inc;
    assign rom_addr_o = pc_q[ADDR_W+1:2];
    assign retire_o   = retire_q;
    assign halted_o   = (state_q == HALTED);
    assign trap_o     = trap_q;
    assign inst_cnt_o = cnt_q;

    // Sequential fetch past the last ROM word wraps back to RESET_PC.
    always_comb begin
        npc = pc_inc;
        case (npc_op)
            3'b000:  npc = (&rom_addr_o) ? RESET_PC : pc_inc;
            3'b001,
            3'b010:  npc = pc_q + immout;
            3'b100:  npc = (rs1_data + immout) & ~32'h1;
            default: npc = pc_inc;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        retire_d = 1'b0;
        trap_d   = trap_q;
        cnt_d    = cnt_q;
        if (clr) begin
            state_d = PAUSED;
            pc_d    = RESET_PC;
            trap_d  = 1'b0;
            cnt_d   = 16'd0;
        end else begin
            case (state_q)
                PAUSED: begin
                    if (step_en) state_d = RUN;
                end
                RUN: begin
                    if (!step_en) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        if (npc[1]) begin
                            trap_d  = 1'b1;
                            state_d = HALTED;
                        end else begin
                            pc_d     = npc;
                            retire_d = 1'b1;
                            cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                            if (npc == pc_q) state_d = HALTED;
                        end
                    end
                end
                default: state_d = HALTED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= PAUSED;
            pc_q     <= RESET_PC;
            retire_q <= 1'b0;
            trap_q   <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            retire_q <= retire_d;
            trap_q   <= trap_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a behavioural model is stepped alongside the DUT
// and every output is compared after each clock; literal checks pin the model.
module tb_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        tick = 1'b0;
    logic        step_en = 1'b0;
    logic        clr = 1'b0;
    logic [2:0]  npc_op = 3'b000;
    logic [31:0] immout = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [5:0]  rom_addr_o;
    logic        retire_o;
    logic        halted_o;
    logic        trap_o;
    logic [15:0] inst_cnt_o;

    int checks = 0;
    int errors = 0;
    int retire_seen = 0;

    // Model state: mode 0 = paused, 1 = running, 2 = halted
    int          m_mode = 0;
    logic [31:0] m_pc = RST_PC;
    logic        m_ret = 1'b0;
    logic        m_trap = 1'b0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    pc_unit #(.RESET_PC(RST_PC), .ADDR_W(6)) dut (
        .clk(clk), .rstn(rstn), .tick(tick), .step_en(step_en), .clr(clr),
        .npc_op(npc_op), .immout(immout), .rs1_data(rs1_data),
        .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .rom_addr_o(rom_addr_o),
        .retire_o(retire_o), .halted_o(halted_o), .trap_o(trap_o),
        .inst_cnt_o(inst_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] target();
        case (npc_op)
            3'd1, 3'd2: return m_pc + immout;
            3'd4:       return (rs1_data + immout) & 32'hFFFF_FFFE;
            3'd0:       return (((m_pc / 4) % 64) == 63) ? RST_PC : m_pc + 4;
            default:    return m_pc + 4;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] t;
        m_ret = 1'b0;
        if (!rstn || clr) begin
            m_mode = 0;
            m_pc   = RST_PC;
            m_trap = 1'b0;
            m_cnt  = 0;
        end else if (m_mode == 0) begin
            if (step_en) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!step_en) m_mode = 0;
            else if (tick) begin
                t = target();
                if (t[1]) begin
                    m_trap = 1'b1;
                    m_mode = 2;
                end else begin
                    if (t == m_pc) m_mode = 2;
                    m_pc  = t;
                    m_ret = 1'b1;
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("pc", pc_o, m_pc);
        chk("pc_plus4", pc_plus4_o, m_pc + 32'd4);
        chk("rom_addr", {26'd0, rom_addr_o}, (m_pc >> 2) % 64);
        chk("retire", {31'd0, retire_o}, {31'd0, m_ret});
        chk("halted", {31'd0, halted_o}, (m_mode == 2) ? 32'd1 : 32'd0);
        chk("trap", {31'd0, trap_o}, {31'd0, m_trap});
        chk("inst_cnt", {16'd0, inst_cnt_o}, m_cnt);
        if (retire_o) retire_seen++;
    endtask

    task automatic cyc(input logic t, input logic s, input logic c, input logic r);
        tick = t; step_en = s; clr = c; rstn = r;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic op(input logic [2:0] o, input logic [31:0] imm, input logic [31:0] rs1);
        npc_op = o; immout = imm; rs1_data = rs1;
    endtask

    initial begin
        // Reset values
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_plus4", pc_plus4_o, 32'h4);
        chk("rst_rom", {26'd0, rom_addr_o}, 32'h0);
        chk("rst_cnt", {16'd0, inst_cnt_o}, 32'h0);

        // Tick while paused is ignored; step_en only starts running
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("start_no_update", pc_o, 32'h0);

        // Normal stepping: five ticks
        retire_seen = 0;
        op(3'b000, 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1);
            cyc(1'b0, 1'b1, 1'b0, 1'b1);
        end
        chk("step_pc", pc_o, 32'h14);
        chk("step_cnt", {16'd0, inst_cnt_o}, 32'd5);
        chk("step_retires", retire_seen, 32'd5);

        // Branch back to 0x10, then to 0x08, then jalr to 0x30
        op(3'b001, 32'hFFFF_FFFC, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("br_to_10", pc_o, 32'h10);
        op(3'b001, 32'hFFFF_FFF8, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("br_to_08", pc_o, 32'h08);
        op(3'b100, 32'd0, 32'h31);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("jalr_30", pc_o, 32'h30);

        // Undefined op code falls back to pc+4
        op(3'b011, 32'h100, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("other_op", pc_o, 32'h34);

        // step_en low pauses even with tick; resume afterwards
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("pause_hold", pc_o, 32'h34);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);

        // Wrap at the last ROM word
        op(3'b010, 32'hC8, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("jal_fc", pc_o, 32'hFC);
        retire_seen = 0;
        op(3'b000, 32'd0, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("wrap_pc", pc_o, 32'h0);
        chk("wrap_rom", {26'd0, rom_addr_o}, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("wrap_retires", retire_seen, 32'd1);

        // Trap on misaligned jal target from 0x20
        op(3'b010, 32'h20, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        op(3'b010, 32'h6, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("trap_pc", pc_o, 32'h20);
        chk("trap_flag", {31'd0, trap_o}, 32'd1);
        chk("trap_halt", {31'd0, halted_o}, 32'd1);
        chk("trap_no_ret", {31'd0, retire_o}, 32'd0);
        op(3'b000, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("halt_hold", pc_o, 32'h20);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_pc", pc_o, 32'h0);
        chk("clr_trap", {31'd0, trap_o}, 32'd0);
        chk("clr_halt", {31'd0, halted_o}, 32'd0);

        // Self-loop: one retire, then halted with frozen count
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        op(3'b001, 32'd0, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("loop_ret", {31'd0, retire_o}, 32'd1);
        chk("loop_cnt", {16'd0, inst_cnt_o}, 32'd2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("loop_halt", {31'd0, halted_o}, 32'd1);
        chk("loop_cnt_hold", {16'd0, inst_cnt_o}, 32'd2);
        chk("loop_trap", {31'd0, trap_o}, 32'd0);

        // clr beats tick
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        op(3'b000, 32'd0, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("pre_clr_pc", pc_o, 32'h8);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_tick_pc", pc_o, 32'h0);
        chk("clr_tick_ret", {31'd0, retire_o}, 32'd0);
        chk("clr_tick_cnt", {16'd0, inst_cnt_o}, 32'd0);

        // Reset beats an accepted tick and clr
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_tick_pc", pc_o, 32'h0);
        chk("rst_tick_ret", {31'd0, retire_o}, 32'd0);
        chk("rst_tick_cnt", {16'd0, inst_cnt_o}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("post_rst_paused", pc_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
